// File: rtl/pulse_cmd_sender.sv
// pulse_cmd_sender: host-side command sender for the pulse-board UART receiver.
// Queues (ctrl, data) commands in a small FIFO, sends each one as a 5-byte
// frame (data LSB first, then ctrl) through a byte-level UART, then waits for
// the receiver's 1-byte checksum echo and reports ok / checksum error / timeout.
//
// Ports:
//   clk, rst            master clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; accepted when both high at posedge
//   cmd_ctrl, cmd_data  control byte and 32-bit value of the command
//   transmit, tx_byte   one-cycle send strobe and byte to the UART
//   is_transmitting     UART busy
//   received, rx_byte   UART byte-received strobe and byte
//   busy                frame in progress
//   done                one-cycle completion pulse, qualifies the three flags
//   ack_ok, err_checksum, err_timeout   command result, valid with done
//   echo_byte           last echo byte accepted while waiting for one
//   fifo_count          command FIFO occupancy
module pulse_cmd_sender #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_ctrl,
  input  logic [31:0]                 cmd_data,
  output logic                        transmit,
  output logic [7:0]                  tx_byte,
  input  logic                        is_transmitting,
  input  logic                        received,
  input  logic [7:0]                  rx_byte,
  output logic                        busy,
  output logic                        done,
  output logic                        ack_ok,
  output logic                        err_checksum,
  output logic                        err_timeout,
  output logic [7:0]                  echo_byte,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_WAIT_ECHO,
    S_REPORT
  } state_t;

  state_t          state;
  logic [39:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            push;
  logic            pop;
  logic [39:0]     head;
  logic [7:0]      head_sum;
  logic [39:0]     frame_q;
  logic [7:0]      exp_sum;
  logic [2:0]      idx;
  logic [1:0]      hi_cnt;
  logic [TW-1:0]   timer;
  logic [7:0]      cur_byte;

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == S_IDLE) && (fifo_count != '0);
  assign head = mem[rd_ptr];
  assign head_sum = head[7:0] + head[15:8] + head[23:16] + head[31:24];

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CW'(1);
      2'b01:   count_nxt = fifo_count - CW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cmd_ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      cmd_ready  <= (count_nxt != FULL_COUNT);
    end
  end

  // FIFO storage: {ctrl, data}.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_ctrl, cmd_data};
  end

  // Frame byte order: data LSB first, ctrl last.
  always_comb begin
    cur_byte = frame_q[39:32];
    case (idx)
      3'd0:    cur_byte = frame_q[7:0];
      3'd1:    cur_byte = frame_q[15:8];
      3'd2:    cur_byte = frame_q[23:16];
      3'd3:    cur_byte = frame_q[31:24];
      default: cur_byte = frame_q[39:32];
    endcase
  end

  // Frame sequencer; strobes and status flags default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      frame_q      <= '0;
      exp_sum      <= '0;
      idx          <= '0;
      hi_cnt       <= '0;
      timer        <= '0;
      transmit     <= 1'b0;
      tx_byte      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_ok       <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      echo_byte    <= '0;
    end else begin
      transmit     <= 1'b0;
      done         <= 1'b0;
      ack_ok       <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            frame_q <= head;
            exp_sum <= head_sum;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!is_transmitting) begin
            tx_byte  <= cur_byte;
            transmit <= 1'b1;
            hi_cnt   <= '0;
            state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // Give the UART up to 4 cycles to raise busy before moving on.
          if (is_transmitting || hi_cnt == 2'd3) begin
            state <= S_WAIT_LO;
          end else begin
            hi_cnt <= hi_cnt + 2'd1;
          end
        end
        S_WAIT_LO: begin
          if (!is_transmitting) begin
            if (idx < 3'd4) begin
              idx   <= idx + 3'd1;
              state <= S_SEND;
            end else begin
              timer <= '0;
              state <= S_WAIT_ECHO;
            end
          end
        end
        S_WAIT_ECHO: begin
          timer <= timer + TW'(1);
          // An echo arriving on the expiry cycle still counts as an echo.
          if (received) begin
            echo_byte    <= rx_byte;
            done         <= 1'b1;
            ack_ok       <= (rx_byte == exp_sum);
            err_checksum <= (rx_byte != exp_sum);
            state        <= S_REPORT;
          end else if (timer == TIMER_LAST) begin
            done        <= 1'b1;
            err_timeout <= 1'b1;
            state       <= S_REPORT;
          end
        end
        S_REPORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_cmd_sender.sv
// tb_pulse_cmd_sender: directed bench for pulse_cmd_sender with a simple UART
// model (captures each strobed byte, stays busy for 3 cycles) and hand-driven
// echo bytes. Inputs are driven and outputs sampled 1 time unit after posedge.
module tb_pulse_cmd_sender;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_ctrl;
  logic [31:0] cmd_data;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        received;
  logic [7:0]  rx_byte;
  logic        busy;
  logic        done;
  logic        ack_ok;
  logic        err_checksum;
  logic        err_timeout;
  logic [7:0]  echo_byte;
  logic [$clog2(DEPTH):0] fifo_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  txq[$];

  pulse_cmd_sender #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl), .cmd_data(cmd_data),
    .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .received(received), .rx_byte(rx_byte),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err_checksum(err_checksum),
    .err_timeout(err_timeout), .echo_byte(echo_byte), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // UART model: capture strobed byte on the falling edge, busy for 3 cycles.
  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit === 1'b1) begin
        txq.push_back(tx_byte);
        is_transmitting = 1'b1;
        repeat (3) @(negedge clk);
        is_transmitting = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [31:0] d);
    cmd_ctrl  = c;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_echo(input logic [7:0] b);
    rx_byte  = b;
    received = 1'b1;
    tick();
    received = 1'b0;
  endtask

  // Wait until n bytes were sent and the UART has gone idle again.
  task automatic wait_frame_end(input int n);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (txq.size() >= n && !is_transmitting) begin ok = 1; break; end
      tick();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL frame_end: got %0d bytes, required %0d with UART idle", txq.size(), n);
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      tick();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_done: done never pulsed within 400 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_ctrl = '0; cmd_data = '0;
    received = 1'b0; rx_byte = '0;
    repeat (3) tick();
    vectors++; if (transmit !== 1'b0) begin miscompares++; $display("FAIL rst_transmit: got %b required 0", transmit); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b required 0", busy); end
    vectors++; if ({done, ack_ok, err_checksum, err_timeout} !== 4'b0) begin miscompares++;
      $display("FAIL rst_status: got %b required 0000", {done, ack_ok, err_checksum, err_timeout}); end
    vectors++; if (echo_byte !== 8'h00) begin miscompares++; $display("FAIL rst_echo: got %h required 00", echo_byte); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b required 0", cmd_ready); end
    rst = 1'b0;
    tick();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_rst: got %b required 1", cmd_ready); end
  endtask

  task automatic test_ack();
    logic [7:0] exp_b [5] = '{8'h10, 8'h27, 8'h00, 8'h00, 8'h01};
    txq.delete();
    push(8'h01, 32'h0000_2710);
    wait_frame_end(5);
    tick();
    pulse_echo(8'h37);
    wait_done();
    vectors++; if ({ack_ok, err_checksum, err_timeout} !== 3'b100) begin miscompares++;
      $display("FAIL ack_flags: got %b required 100", {ack_ok, err_checksum, err_timeout}); end
    vectors++; if (echo_byte !== 8'h37) begin miscompares++; $display("FAIL ack_echo: got %h required 37", echo_byte); end
    vectors++; if (txq.size() != 5) begin miscompares++; $display("FAIL ack_len: got %0d required 5", txq.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (txq[i] !== exp_b[i]) begin miscompares++;
        $display("FAIL ack_byte%0d: got %h required %h", i, txq[i], exp_b[i]); end
    end
    tick();
    vectors++; if ({done, busy, ack_ok} !== 3'b000) begin miscompares++;
      $display("FAIL ack_after: done/busy/ack got %b required 000", {done, busy, ack_ok}); end
  endtask

  task automatic test_checksum();
    logic [7:0] exp_b [5] = '{8'h00, 8'h7F, 8'h00, 8'h00, 8'h06};
    txq.delete();
    push(8'h06, 32'h0000_7F00);
    wait_frame_end(5);
    tick();
    pulse_echo(8'h00);
    wait_done();
    vectors++; if ({ack_ok, err_checksum, err_timeout} !== 3'b010) begin miscompares++;
      $display("FAIL cks_flags: got %b required 010", {ack_ok, err_checksum, err_timeout}); end
    vectors++; if (echo_byte !== 8'h00) begin miscompares++; $display("FAIL cks_echo: got %h required 00", echo_byte); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (txq[i] !== exp_b[i]) begin miscompares++;
        $display("FAIL cks_byte%0d: got %h required %h", i, txq[i], exp_b[i]); end
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    txq.delete();
    push(8'h02, 32'h1234_5678);
    // Returns on the first cycle whose clock edge sampled the 5th byte's fall.
    wait_frame_end(5);
    while (done !== 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
    vectors++; if (cnt != 100) begin miscompares++; $display("FAIL to_latency: got %0d cycles required 100", cnt); end
    vectors++; if ({ack_ok, err_checksum, err_timeout} !== 3'b001) begin miscompares++;
      $display("FAIL to_flags: got %b required 001", {ack_ok, err_checksum, err_timeout}); end
    tick();
    pulse_echo(8'hAA);
    tick();
    vectors++; if (echo_byte !== 8'h00) begin miscompares++; $display("FAIL to_stray_echo: got %h required 00", echo_byte); end
    vectors++; if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL to_stray_state: done/busy got %b required 00", {done, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  c [6]   = '{8'h03, 8'h04, 8'h05, 8'h07, 8'h00, 8'h02};
    logic [31:0] d [6]   = '{32'h0000_0011, 32'h0101_0101, 32'hA0B0_C0D0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [7:0]  sums [5] = '{8'h11, 8'h04, 8'hE0, 8'hFC, 8'h14};
    logic [7:0]  eb;
    txq.delete();
    for (int i = 0; i < 5; i++) begin
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b required 1", i, cmd_ready); end
      push(c[i], d[i]);
    end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL b2b_full_count: got %0d required 4", fifo_count); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready: got %b required 0", cmd_ready); end
    push(c[5], d[5]);
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL b2b_ignored_push: count got %0d required 4", fifo_count); end
    for (int k = 0; k < 5; k++) begin
      wait_frame_end(5 * (k + 1));
      tick();
      pulse_echo(sums[k]);
      wait_done();
      vectors++; if (ack_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_ack%0d: got %b required 1", k, ack_ok); end
      tick();
      vectors++; if (transmit !== 1'b0) begin miscompares++; $display("FAIL b2b_gap%0d: transmit got %b required 0", k, transmit); end
    end
    tick();
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL b2b_drain: count got %0d required 0", fifo_count); end
    vectors++; if (txq.size() != 25) begin miscompares++; $display("FAIL b2b_len: got %0d required 25", txq.size()); end
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 5; j++) begin
        eb = (j < 4) ? d[k][8*j +: 8] : c[k];
        vectors++; if (txq[5*k + j] !== eb) begin miscompares++;
          $display("FAIL b2b_byte%0d_%0d: got %h required %h", k, j, txq[5*k + j], eb); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    bit saw_done = 0;
    logic [7:0] exp_b [5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    txq.delete();
    push(8'h05, 32'hAABB_CCDD);
    push(8'h06, 32'h1122_3344);
    for (int i = 0; i < 200; i++) begin
      if (transmit === 1'b1 && txq.size() == 2) begin hit = 1; break; end
      tick();
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL rmid_third_byte: 3rd strobe not seen"); end
    rst = 1'b1;
    tick();
    vectors++; if ({transmit, busy, done} !== 3'b000) begin miscompares++;
      $display("FAIL rmid_abort: transmit/busy/done got %b required 000", {transmit, busy, done}); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL rmid_count: got %0d required 0", fifo_count); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1 || transmit === 1'b1) saw_done = 1;
    end
    vectors++; if (saw_done) begin miscompares++; $display("FAIL rmid_quiet: got done/transmit activity required none"); end
    txq.delete();
    push(8'h04, 32'h0000_0001);
    wait_frame_end(5);
    tick();
    pulse_echo(8'h01);
    wait_done();
    vectors++; if (ack_ok !== 1'b1) begin miscompares++; $display("FAIL rmid_ack: got %b required 1", ack_ok); end
    vectors++; if (txq.size() != 5) begin miscompares++; $display("FAIL rmid_len: got %0d required 5", txq.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (txq[i] !== exp_b[i]) begin miscompares++;
        $display("FAIL rmid_byte%0d: got %h required %h", i, txq[i], exp_b[i]); end
    end
  endtask

  task automatic test_early_echo();
    bit hit = 0;
    txq.delete();
    push(8'h07, 32'h0102_0304);
    for (int i = 0; i < 200; i++) begin
      if (txq.size() == 2 && is_transmitting) begin hit = 1; break; end
      tick();
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL early_2nd_byte: 2nd byte not seen in flight"); end
    pulse_echo(8'h55);
    tick();
    vectors++; if (echo_byte !== 8'h01) begin miscompares++; $display("FAIL early_echo_kept: got %h required 01", echo_byte); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL early_no_done: got %b required 0", done); end
    wait_frame_end(5);
    tick();
    pulse_echo(8'h0A);
    wait_done();
    vectors++; if ({ack_ok, err_checksum, err_timeout} !== 3'b100) begin miscompares++;
      $display("FAIL early_flags: got %b required 100", {ack_ok, err_checksum, err_timeout}); end
    vectors++; if (echo_byte !== 8'h0A) begin miscompares++; $display("FAIL early_echo: got %h required 0A", echo_byte); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_checksum();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_early_echo();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
